vmul_sequencer: RTL and testbench

Sequencer for a single shared fixed-point multiplier in the vector accelerator. It accepts a vector-length command, then streams that many operand pairs through one registered multiplier stage, and emits one product per pair with last-element marking and a completion pulse. It sits between the operand fetch stream and the result write-back stream. It owns all valid/ready handshaking and element counting for the multiply datapath.

---
 rtl/vmul_sequencer.sv | 129 ++++++++++++
 tb/tb_vmul_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmul_sequencer.sv
// Valid/ready sequencer around one registered fixed-point multiplier stage.
// Define VMUL_SAT_EN to clamp out-of-range products instead of wrapping.
module vmul_sequencer #(
  parameter int unsigned BITS      = 8,
  parameter int unsigned OUT_SHIFT = 0,
  parameter int unsigned MAX_LEN   = 256,
  localparam int unsigned LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BITS-1:0]  in_a,
  input  logic [BITS-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BITS-1:0]  out_p,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned TOP = OUT_SHIFT + BITS - 1;
`ifdef VMUL_SAT_EN
  localparam int unsigned FULL_W = 2 * BITS;
`else
  // Bits above the output slice never influence it, so they are not built.
  localparam int unsigned FULL_W = OUT_SHIFT + BITS;
`endif
  localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            state_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_q;
  logic [LEN_W-1:0]  len_clamped;
  logic signed [FULL_W-1:0] full;
  logic [BITS-1:0]   prod;
  logic              cmd_hs;
  logic              in_hs;
  logic              out_hs;
  logic              is_last;

  assign full = FULL_W'($signed(in_a)) * FULL_W'($signed(in_b));

`ifdef VMUL_SAT_EN
  logic signed [FULL_W-1:0] full_hi;

  // full_hi is all-zero or all-one exactly when the slice represents full.
  always_comb begin
    full_hi = full >>> TOP;
    if ((full_hi == '0) || (full_hi == '1)) begin
      prod = full[OUT_SHIFT +: BITS];
    end else if (full[FULL_W-1]) begin
      prod = {1'b1, {(BITS-1){1'b0}}};
    end else begin
      prod = {1'b0, {(BITS-1){1'b1}}};
    end
  end
`else
  assign prod = full[OUT_SHIFT +: BITS];
`endif

  always_comb begin
    cmd_ready   = (state_q == StIdle);
    busy        = (state_q != StIdle);
    in_ready    = (state_q == StRun) && (!out_valid || out_ready);
    cmd_hs      = cmd_valid && cmd_ready;
    in_hs       = in_valid && in_ready;
    out_hs      = out_valid && out_ready;
    is_last     = (issued_q == (len_q - 1'b1));
    len_clamped = (cmd_len > MAX_LEN_W) ? MAX_LEN_W : cmd_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      len_q     <= '0;
      issued_q  <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      // A same-cycle output handshake is covered by the reload.
      if (in_hs) begin
        out_p     <= prod;
        out_last  <= is_last;
        out_valid <= 1'b1;
        issued_q  <= issued_q + 1'b1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (cmd_hs) begin
            len_q    <= len_clamped;
            issued_q <= '0;
            if (len_clamped == '0) begin
              done <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (in_hs && is_last) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (out_hs && out_last) begin
            state_q <= StIdle;
            done    <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vmul_sequencer.sv
// Randomized bench for vmul_sequencer against a count-based reference model.
// A second instance with OUT_SHIFT=4 shares the stimulus.
module tb_vmul_sequencer;

  localparam int BITS    = 8;
  localparam int MAX_LEN = 256;
  localparam int LEN_W   = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic [LEN_W-1:0] cmd_len;
  logic             in_valid;
  logic [BITS-1:0]  in_a;
  logic [BITS-1:0]  in_b;
  logic             out_ready;

  logic             cmd_ready, in_ready, out_valid, out_last, busy, done;
  logic [BITS-1:0]  out_p;
  logic             cmd_ready4, in_ready4, out_valid4, out_last4, busy4, done4;
  logic [BITS-1:0]  out_p4;

  always #5 clk = ~clk;

  vmul_sequencer #(.BITS(BITS), .OUT_SHIFT(0), .MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  vmul_sequencer #(.BITS(BITS), .OUT_SHIFT(4), .MAX_LEN(MAX_LEN)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready4),
    .cmd_len   (cmd_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .out_p     (out_p4),
    .out_last  (out_last4),
    .busy      (busy4),
    .done      (done4)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: command in progress, elements left to accept, held product.
  bit         m_active, m_ov, m_last, m_done, m_after_rst, m_in_hs;
  int         m_todo;
  logic [7:0] m_p, m_p4;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit         ordy_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_prod(input logic [7:0] a, input logic [7:0] b,
                                          input int sh);
    int full;
    int v;
    full = int'($signed(a)) * int'($signed(b));
    v = full >>> sh;
`ifdef VMUL_SAT_EN
    if (v > 127) v = 127;
    else if (v < -128) v = -128;
`endif
    return v[7:0];
  endfunction

  task automatic model_reset();
    m_active    = 1'b0;
    m_todo      = 0;
    m_ov        = 1'b0;
    m_last      = 1'b0;
    m_done      = 1'b0;
    m_after_rst = 1'b1;
    m_in_hs     = 1'b0;
  endtask

  // One clock: compare outputs at the falling edge, then advance the model.
  task automatic step();
    bit e_cmd, e_in, e_out, e_ir, drain_done;
    int l;
    @(negedge clk);
    e_ir = m_active && (m_todo > 0) && (!m_ov || out_ready);
    check_eq("cmd_ready", 32'(cmd_ready), 32'(!m_active));
    check_eq("in_ready", 32'(in_ready), 32'(e_ir));
    check_eq("busy", 32'(busy), 32'(m_active));
    check_eq("done", 32'(done), 32'(m_done));
    check_eq("out_valid", 32'(out_valid), 32'(m_ov));
    check_eq("in_ready_s4", 32'(in_ready4), 32'(e_ir));
    check_eq("out_valid_s4", 32'(out_valid4), 32'(m_ov));
    if (m_ov) begin
      check_eq("out_p", 32'(out_p), 32'(m_p));
      check_eq("out_last", 32'(out_last), 32'(m_last));
      check_eq("out_p_s4", 32'(out_p4), 32'(m_p4));
    end
    if (m_after_rst) begin
      check_eq("rst_out_p", 32'(out_p), 32'(0));
      check_eq("rst_out_last", 32'(out_last), 32'(0));
      check_eq("rst_out_p_s4", 32'(out_p4), 32'(0));
    end
    e_cmd = cmd_valid && !m_active;
    e_in  = in_valid && e_ir;
    e_out = m_ov && out_ready;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      drain_done = m_active && (m_todo == 0) && e_out && m_last;
      m_done  = drain_done;
      m_in_hs = e_in;
      if (e_in) begin
        m_ov        = 1'b1;
        m_p         = ref_prod(in_a, in_b, 0);
        m_p4        = ref_prod(in_a, in_b, 4);
        m_last      = (m_todo == 1);
        m_todo      = m_todo - 1;
        m_after_rst = 1'b0;
      end else if (e_out) begin
        m_ov = 1'b0;
      end
      if (e_cmd) begin
        l = int'(cmd_len);
        if (l > MAX_LEN) l = MAX_LEN;
        if (l == 0) begin
          m_done = 1'b1;
        end else begin
          m_active = 1'b1;
          m_todo   = l;
        end
      end
      if (drain_done) m_active = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_valid = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  // Issue one command and feed it; abort_at >= 0 asserts rst after that many inputs.
  task automatic run_cmd(input int len, input int vpct, input int orpct, input int abort_at);
    int acc = 0;
    int cyc = 0;
    logic [7:0] a, b;
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    in_valid  = 1'($urandom_range(0, 1));
    in_a      = 8'($urandom);
    in_b      = 8'($urandom);
    out_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    if (qa.size() > 0) begin a = qa.pop_front(); b = qb.pop_front(); end
    else begin a = 8'($urandom); b = 8'($urandom); end
    while (m_active) begin
      if (cyc > 3000) begin
        check_eq("timeout", 32'(cyc), 32'(0));
        break;
      end
      if (abort_at >= 0 && acc == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        break;
      end
      in_valid  = ($urandom_range(1, 100) <= vpct);
      in_a      = a;
      in_b      = b;
      out_ready = (ordy_q.size() > 0) ? ordy_q.pop_front() : ($urandom_range(1, 100) <= orpct);
      cmd_valid = ($urandom_range(0, 9) == 0);
      cmd_len   = LEN_W'($urandom);
      step();
      cyc++;
      if (m_in_hs) begin
        acc++;
        if (qa.size() > 0) begin a = qa.pop_front(); b = qb.pop_front(); end
        else begin a = 8'($urandom); b = 8'($urandom); end
      end
    end
    cmd_valid = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    idle(2);

    qa = '{8'h03, 8'hFE, 8'h00};
    qb = '{8'h04, 8'h05, 8'hF9};
    run_cmd(3, 100, 100, -1);
    idle(1);

    qa = '{8'h10, 8'h80};
    qb = '{8'h10, 8'h02};
    run_cmd(2, 100, 100, -1);

    // Back-to-back: this command lands in the done cycle of the previous one.
    qa = '{8'h20};
    qb = '{8'h30};
    run_cmd(1, 100, 100, -1);

    ordy_q = '{1'b1, 1'b0, 1'b0, 1'b0};
    run_cmd(4, 100, 100, -1);

    run_cmd(0, 100, 100, -1);
    idle(2);

    run_cmd(5, 100, 100, 2);
    idle(1);
    run_cmd(2, 100, 100, -1);
    idle(1);

    run_cmd(300, 100, 90, -1);

    for (int i = 0; i < 30; i++) begin
      run_cmd(int'($urandom_range(0, 12)), 70, 70, -1);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 2)));
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
